// File: rtl/div_seq_32x16_pkg.sv
// Shared constants and state encoding for the 32/16 sequential divider.
package div_seq_32x16_pkg;

  localparam int unsigned DIV_W = 16;

  // Quotient reported for both error cases.
  localparam logic [DIV_W-1:0] ERR_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: 17-bit trial subtract of the divisor.
module div_step
  import div_seq_32x16_pkg::*;
(
  input  logic [DIV_W:0]   i_trial,
  input  logic [DIV_W-1:0] i_divisor,
  output logic [DIV_W:0]   o_diff,
  output logic             o_borrow
);

  logic [DIV_W+1:0] w_full;

  // Extra top bit captures the borrow (negative result).
  assign w_full   = {1'b0, i_trial} - {2'b00, i_divisor};
  assign o_diff   = w_full[DIV_W:0];
  assign o_borrow = w_full[DIV_W+1];

endmodule

// File: rtl/div_seq_32x16.sv
// Radix-2 restoring divider, 32-bit dividend by 16-bit divisor, one quotient bit per cycle.
module div_seq_32x16
  import div_seq_32x16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [31:0]       i_dividend,
  input  logic [DIV_W-1:0]  i_divisor,
  output logic              o_busy,
  output logic              o_done,
  output logic [DIV_W-1:0]  o_quotient,
  output logic [DIV_W-1:0]  o_remainder,
  output logic              o_div_by_zero,
  output logic              o_overflow
);

  state_e           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_dvs;
  // r_rem holds the partial remainder; r_quo shifts dividend bits out (MSB first)
  // while quotient bits shift in at the bottom, ending as the quotient.
  logic [DIV_W-1:0] r_rem, r_quo;
  logic [4:0]       r_cnt;
  logic             r_dbz, r_ovf;

  logic             w_accept, w_err_dbz, w_err_ovf, w_last, w_borrow;
  logic [DIV_W:0]   w_trial, w_diff;
  logic             w_unused_msb;

  assign w_accept  = (r_state == StIdle) && i_start;
  assign w_err_dbz = (i_divisor == '0);
  assign w_err_ovf = (i_dividend[31:16] >= i_divisor);
  assign w_last    = (r_cnt == 5'd15);
  assign w_trial   = {r_rem, r_quo[DIV_W-1]};

  div_step u_div_step (
    .i_trial   (w_trial),
    .i_divisor (r_dvs),
    .o_diff    (w_diff),
    .o_borrow  (w_borrow)
  );

  // A non-negative trial result is always below the divisor, so its MSB is zero.
  assign w_unused_msb = w_diff[DIV_W];

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_nxt = (w_err_dbz || w_err_ovf) ? StDone : StCalc;
      end
      StCalc: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = StDone;
      end
      StDone: begin
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath: loads only on an accepted start, updates only while calculating.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dvs <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_dvs <= i_divisor;
      r_cnt <= '0;
      if (w_err_dbz) begin
        r_dbz <= 1'b1;
        r_ovf <= 1'b0;
        r_quo <= ERR_QUOT;
        r_rem <= i_dividend[DIV_W-1:0];
      end else if (w_err_ovf) begin
        r_dbz <= 1'b0;
        r_ovf <= 1'b1;
        r_quo <= ERR_QUOT;
        r_rem <= '0;
      end else begin
        r_dbz <= 1'b0;
        r_ovf <= 1'b0;
        r_rem <= i_dividend[31:16];
        r_quo <= i_dividend[DIV_W-1:0];
      end
    end else if (r_state == StCalc) begin
      r_cnt <= r_cnt + 5'd1;
      r_quo <= {r_quo[DIV_W-2:0], ~w_borrow};
      // On borrow keep the shifted value (restore), else take the difference.
      r_rem <= w_borrow ? w_trial[DIV_W-1:0] : w_diff[DIV_W-1:0];
    end
  end

  assign o_quotient    = r_quo;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;
  assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_div_seq_32x16.sv
// Scoreboard bench for div_seq_32x16 against a plain-arithmetic reference model.
module tb_div_seq_32x16;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, dbz, ovf;
  logic [15:0] quotient, remainder;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          done_cyc;
    int          busy_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t last_e;
  bit   has_last = 1'b0;
  int   busy_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq_32x16 dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz),
    .o_overflow    (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: integer division with the two error rules on top.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0] q32;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 16'd0) begin
      e.dbz = 1'b1;
      e.q = 16'hFFFF;
      e.r = a[15:0];
      e.busy_n = 0;
    end else begin
      q32 = a / {16'd0, b};
      if (q32 > 32'h0000_FFFF) begin
        e.ovf = 1'b1;
        e.q = 16'hFFFF;
        e.r = 16'h0000;
        e.busy_n = 0;
      end else begin
        e.q = q32[15:0];
        q32 = a % {16'd0, b};
        e.r = q32[15:0];
        e.busy_n = 16;
      end
    end
    e.done_cyc = 0;
    return e;
  endfunction

  // Drive one start pulse and push the expected result.
  task automatic issue(input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e = model(a, b);
    e.done_cyc = cyc + ((e.dbz || e.ovf) ? 1 : 17);
    sb.push_back(e);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every done pulse; checks hold while idle.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want none (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("quotient", 64'(quotient), 64'(mon_e.q));
          check("remainder", 64'(remainder), 64'(mon_e.r));
          check("flags", 64'({dbz, ovf}), 64'({mon_e.dbz, mon_e.ovf}));
          check("latency", 64'(cyc), 64'(mon_e.done_cyc));
          check("busy_cycles", 64'(busy_cnt), 64'(mon_e.busy_n));
          check("busy_at_done", 64'(busy), 64'd0);
          last_e   = mon_e;
          has_last = 1'b1;
        end
        busy_cnt = 0;
      end else if (has_last && !busy) begin
        check("hold", 64'({quotient, remainder, dbz, ovf}),
              64'({last_e.q, last_e.r, last_e.dbz, last_e.ovf}));
      end
    end
  end

  initial begin
    int k;
    logic [15:0] b, hi;
    int mode;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, quotient, remainder, dbz, ovf}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(32'h0626_0065, 16'h5678); drain();
    issue(32'h0000_0064, 16'h0007); drain();
    issue(32'hABCD_1234, 16'h0000); drain();
    issue(32'h0001_0000, 16'h0001); drain();

    // Extra start pulses during CALC cycles 3 and 10 and during DONE must be ignored.
    @(posedge clk); #1;
    dividend = 32'h0626_0065;
    divisor  = 16'h5678;
    start    = 1'b1;
    k = cyc;
    begin
      exp_t e;
      e = model(32'h0626_0065, 16'h5678);
      e.done_cyc = k + 17;
      sb.push_back(e);
    end
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      start    = (i == 3 || i == 10 || i == 17);
      dividend = $urandom;
      divisor  = 16'($urandom_range(1, 65535));
    end
    start = 1'b0;
    drain();
    repeat (20) @(posedge clk);

    // Reset at CALC cycle 8 with start held: aborts, no done, outputs cleared.
    @(posedge clk); #1;
    dividend = 32'h0000_0064;
    divisor  = 16'h0007;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    start    = 1'b1;
    has_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_outputs", 64'({busy, done, quotient, remainder, dbz, ovf}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("idle_after_reset", 64'({busy, done}), 64'd0);
    issue(32'h0000_0064, 16'h0007); drain();

    // Randomized mix of normal, divide-by-zero and overflow cases.
    for (int n = 0; n < 60; n++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        issue($urandom, 16'h0000);
      end else begin
        b = (mode == 2) ? 16'h0001 : (mode == 3) ? 16'hFFFF : 16'($urandom_range(1, 65535));
        if (mode == 1) hi = 16'($urandom_range(int'(b), 65535));
        else           hi = 16'($urandom_range(0, int'(b) - 1));
        issue({hi, 16'($urandom)}, b);
      end
      drain();
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq_32x16.md
DIV_SEQ_32X16 -- requirements
Module: div_seq_32x16

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  request pulse; sampled only while idle.
REQ-004 dividend  input  32  unsigned dividend, e.g. a 16x16 product.
REQ-005 divisor  input  16  unsigned divisor.
REQ-006 busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-007 done  output  1  one-cycle pulse; results valid from this cycle.
REQ-008 quotient  output  16  unsigned quotient.
REQ-009 remainder  output  16  unsigned remainder.
REQ-010 div_by_zero  output  1  error flag: divisor was zero.
REQ-011 overflow  output  1  error flag: the quotient does not fit in 16 bits.

Function
REQ-012 The block SHALL implement a radix-2 restoring divider with three states: IDLE, CALC and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch dividend and divisor, clear both error flags, and leave IDLE.
- The latched operands are the only source of data for the rest of the operation.
REQ-014 If the latched divisor is 0, the block SHALL set div_by_zero=1 and go to DONE.
- quotient=0xFFFF, remainder=dividend[15:0].
REQ-015 Else if dividend[31:16] >= divisor, the block SHALL set overflow=1 and go to DONE.
- quotient=0xFFFF, remainder=0x0000.
REQ-016 Otherwise the block SHALL enter CALC and resolve exactly one quotient bit per cycle, MSB first, for 16 cycles.
- A 5-bit iteration counter counts the bits.
- Each step uses a 17-bit trial subtract of the divisor from {partial_remainder, next_dividend_bit}.
- If the result is non-negative: keep it and set the quotient bit to 1; otherwise restore the partial remainder and set the bit to 0.
REQ-017 After the 16th CALC cycle the block SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 Latency SHALL be fixed:
- Normal operation: done asserted in the 17th cycle after the start-sampling edge.
- Error cases: done asserted in the 1st cycle after the start-sampling edge.
REQ-020 The block SHALL ignore start while busy or in DONE; no queuing.
REQ-021 quotient, remainder and the error flags SHALL hold their values from done until the next accepted start.
REQ-022 The block SHALL guarantee quotient*divisor + remainder = dividend and remainder < divisor for every non-error result.
REQ-023 For low power, the operand registers SHALL load only on an accepted start, and datapath registers SHALL NOT toggle in IDLE.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force state to IDLE and drive busy, done, quotient, remainder, div_by_zero and overflow to 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after reset is accepted normally.
REQ-026 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold:
- constant DIV_W=16;
- the state encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2;
- constant ERR_QUOT=16'hFFFF.
REQ-028 The 17-bit trial subtract SHALL be one sub-module, div_step. It is purely combinational, with outputs diff[16:0] and borrow.
REQ-029 The FSM, iteration counter and registers SHALL live in div_seq_32x16.

Verification
REQ-030 dividend=0x06260065, divisor=0x5678, start pulse -> done after 17 cycles; quotient=0x1234, remainder=0x0005, no flags.
REQ-031 dividend=0x00000064, divisor=0x0007 -> quotient=0x000E, remainder=0x0002; busy high for exactly 16 cycles.
REQ-032 divisor=0x0000, dividend=0xABCD1234 -> done after 1 cycle; div_by_zero=1, quotient=0xFFFF, remainder=0x1234.
REQ-033 dividend=0x00010000, divisor=0x0001 -> done after 1 cycle; overflow=1, quotient=0xFFFF, remainder=0x0000.
REQ-034 Start pulses at CALC cycles 3 and 10 are ignored -> only one done pulse, with the result of the first operands.
REQ-035 rst_n=0 at CALC cycle 8 -> all outputs 0, no done pulse; the next start with 0x64/0x7 gives the REQ-031 result.
